// File: rtl/nbr_table_ctrl.sv
// nbr_table_ctrl
// Sequencing controller for a node's neighbor table. It takes one neighbor
// advertisement at a time and searches the table for the advertised ID. It then
// either rewrites the matching entry or appends a new one. Finally it rescans the
// table and publishes the best next hop: the highest Q, with its ID and hop count.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   pkt_valid/ready     advertisement handshake (ready only while idle)
//   pkt_*               advertisement fields (id, cluster, energy, hops, q)
//   tbl_clr             empty the table (honoured only while idle)
//   tbl_addr, tbl_wr_*  table address, write strobe and write data
//   tbl_rd_*            table read data, valid one cycle after tbl_addr
//   neighbor_count      number of valid entries
//   max_q/best_*        best-neighbor summary, best_valid when meaningful
//   upd_done            one-cycle pulse when an update has finished
//   pkt_dropped         one-cycle pulse (with upd_done) when a new ID finds the table full
//
// Build option: define HOP_TIEBREAK_EN so that, among equal-Q entries, the one
// with fewer hops wins. Without it, the earliest entry with the maximum Q wins.
module nbr_table_ctrl #(
    parameter int WORD_WIDTH    = 16,
    parameter int MAX_NEIGHBORS = 16,
    parameter int ADDR_WIDTH    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [WORD_WIDTH-1:0] pkt_id,
    input  logic [WORD_WIDTH-1:0] pkt_cluster,
    input  logic [WORD_WIDTH-1:0] pkt_energy,
    input  logic [WORD_WIDTH-1:0] pkt_hops,
    input  logic [WORD_WIDTH-1:0] pkt_q,
    input  logic                  tbl_clr,
    output logic [ADDR_WIDTH-1:0] tbl_addr,
    output logic                  tbl_wr_en,
    output logic [WORD_WIDTH-1:0] tbl_wr_id,
    output logic [WORD_WIDTH-1:0] tbl_wr_cluster,
    output logic [WORD_WIDTH-1:0] tbl_wr_energy,
    output logic [WORD_WIDTH-1:0] tbl_wr_hops,
    output logic [WORD_WIDTH-1:0] tbl_wr_q,
    input  logic [WORD_WIDTH-1:0] tbl_rd_id,
    input  logic [WORD_WIDTH-1:0] tbl_rd_hops,
    input  logic [WORD_WIDTH-1:0] tbl_rd_q,
    output logic [ADDR_WIDTH:0]   neighbor_count,
    output logic [WORD_WIDTH-1:0] max_q,
    output logic [WORD_WIDTH-1:0] best_id,
    output logic [WORD_WIDTH-1:0] best_hops,
    output logic                  best_valid,
    output logic                  upd_done,
    output logic                  pkt_dropped
);

    typedef enum logic [2:0] {IDLE, S_ADDR, S_CMP, WRITE, C_ADDR, C_CMP, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH+1)'(MAX_NEIGHBORS);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] widx_q, widx_d;
    logic                  hit_q, hit_d;
    logic                  drop_q, drop_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [WORD_WIDTH-1:0] lat_id_q, lat_id_d;
    logic [WORD_WIDTH-1:0] lat_cluster_q, lat_cluster_d;
    logic [WORD_WIDTH-1:0] lat_energy_q, lat_energy_d;
    logic [WORD_WIDTH-1:0] lat_hops_q, lat_hops_d;
    logic [WORD_WIDTH-1:0] lat_qv_q, lat_qv_d;
    logic [WORD_WIDTH-1:0] run_qv_q, run_qv_d;
    logic [WORD_WIDTH-1:0] run_id_q, run_id_d;
    logic [WORD_WIDTH-1:0] run_hops_q, run_hops_d;
    logic                  run_valid_q, run_valid_d;
    logic [WORD_WIDTH-1:0] max_q_q, max_q_d;
    logic [WORD_WIDTH-1:0] best_id_q, best_id_d;
    logic [WORD_WIDTH-1:0] best_hops_q, best_hops_d;
    logic                  best_valid_q, best_valid_d;

    logic                  is_last;
    logic                  full;
    logic                  cand_wins;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_WIDTH-1:0] sel_qv, sel_id, sel_hops;

    // idx addresses the last valid entry when idx+1 == count
    assign is_last = (({1'b0, idx_q} + CNT_ONE) == count_q);
    assign full    = (count_q == CNT_MAX);
    assign wr_addr = hit_q ? widx_q : count_q[ADDR_WIDTH-1:0];

    // Strict Q improvement always wins; ties keep the earlier entry unless
    // the hop tiebreak is built in.
    always_comb begin
        cand_wins = !run_valid_q || (tbl_rd_q > run_qv_q);
`ifdef HOP_TIEBREAK_EN
        if (run_valid_q && (tbl_rd_q == run_qv_q) && (tbl_rd_hops < run_hops_q))
            cand_wins = 1'b1;
`else
        cand_wins = cand_wins;
`endif
    end

    assign sel_qv   = cand_wins ? tbl_rd_q    : run_qv_q;
    assign sel_id   = cand_wins ? tbl_rd_id   : run_id_q;
    assign sel_hops = cand_wins ? tbl_rd_hops : run_hops_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        widx_d        = widx_q;
        hit_d         = hit_q;
        drop_d        = drop_q;
        count_d       = count_q;
        lat_id_d      = lat_id_q;
        lat_cluster_d = lat_cluster_q;
        lat_energy_d  = lat_energy_q;
        lat_hops_d    = lat_hops_q;
        lat_qv_d      = lat_qv_q;
        run_qv_d      = run_qv_q;
        run_id_d      = run_id_q;
        run_hops_d    = run_hops_q;
        run_valid_d   = run_valid_q;
        max_q_d       = max_q_q;
        best_id_d     = best_id_q;
        best_hops_d   = best_hops_q;
        best_valid_d  = best_valid_q;

        case (state_q)
            IDLE: begin
                if (tbl_clr) begin
                    // Clear wins over a simultaneous packet; the packet waits.
                    count_d      = '0;
                    best_valid_d = 1'b0;
                end else if (pkt_valid) begin
                    lat_id_d      = pkt_id;
                    lat_cluster_d = pkt_cluster;
                    lat_energy_d  = pkt_energy;
                    lat_hops_d    = pkt_hops;
                    lat_qv_d      = pkt_q;
                    idx_d         = '0;
                    hit_d         = 1'b0;
                    drop_d        = 1'b0;
                    state_d       = (count_q == '0) ? WRITE : S_ADDR;
                end
            end
            S_ADDR: state_d = S_CMP;
            S_CMP: begin
                if (tbl_rd_id == lat_id_q) begin
                    hit_d   = 1'b1;
                    widx_d  = idx_q;
                    state_d = WRITE;
                end else if (is_last) begin
                    state_d = WRITE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_ADDR;
                end
            end
            WRITE: begin
                if (!hit_q && full) begin
                    drop_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    if (!hit_q)
                        count_d = count_q + CNT_ONE;
                    idx_d       = '0;
                    run_qv_d    = '0;
                    run_valid_d = 1'b0;
                    state_d     = C_ADDR;
                end
            end
            C_ADDR: state_d = C_CMP;
            C_CMP: begin
                run_qv_d    = sel_qv;
                run_id_d    = sel_id;
                run_hops_d  = sel_hops;
                run_valid_d = 1'b1;
                if (is_last) begin
                    max_q_d      = sel_qv;
                    best_id_d    = sel_id;
                    best_hops_d  = sel_hops;
                    best_valid_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = C_ADDR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            widx_q        <= '0;
            hit_q         <= 1'b0;
            drop_q        <= 1'b0;
            count_q       <= '0;
            lat_id_q      <= '0;
            lat_cluster_q <= '0;
            lat_energy_q  <= '0;
            lat_hops_q    <= '0;
            lat_qv_q      <= '0;
            run_qv_q      <= '0;
            run_id_q      <= '0;
            run_hops_q    <= '0;
            run_valid_q   <= 1'b0;
            max_q_q       <= '0;
            best_id_q     <= '1;
            best_hops_q   <= '1;
            best_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            widx_q        <= widx_d;
            hit_q         <= hit_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            lat_id_q      <= lat_id_d;
            lat_cluster_q <= lat_cluster_d;
            lat_energy_q  <= lat_energy_d;
            lat_hops_q    <= lat_hops_d;
            lat_qv_q      <= lat_qv_d;
            run_qv_q      <= run_qv_d;
            run_id_q      <= run_id_d;
            run_hops_q    <= run_hops_d;
            run_valid_q   <= run_valid_d;
            max_q_q       <= max_q_d;
            best_id_q     <= best_id_d;
            best_hops_q   <= best_hops_d;
            best_valid_q  <= best_valid_d;
        end
    end

    assign pkt_ready      = (state_q == IDLE);
    assign tbl_addr       = (state_q == WRITE) ? wr_addr : idx_q;
    assign tbl_wr_en      = (state_q == WRITE) && (hit_q || !full);
    assign tbl_wr_id      = lat_id_q;
    assign tbl_wr_cluster = lat_cluster_q;
    assign tbl_wr_energy  = lat_energy_q;
    assign tbl_wr_hops    = lat_hops_q;
    assign tbl_wr_q       = lat_qv_q;
    assign neighbor_count = count_q;
    assign max_q          = max_q_q;
    assign best_id        = best_id_q;
    assign best_hops      = best_hops_q;
    assign best_valid     = best_valid_q;
    assign upd_done       = (state_q == DONE);
    assign pkt_dropped    = (state_q == DONE) && drop_q;

endmodule

// File: tb/tb_nbr_table_ctrl.sv
module tb_nbr_table_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [15:0] pkt_id = '0, pkt_cluster = '0, pkt_energy = '0, pkt_hops = '0, pkt_q = '0;
    logic        tbl_clr = 1'b0;
    logic [3:0]  tbl_addr;
    logic        tbl_wr_en;
    logic [15:0] tbl_wr_id, tbl_wr_cluster, tbl_wr_energy, tbl_wr_hops, tbl_wr_q;
    logic [15:0] tbl_rd_id = '0, tbl_rd_hops = '0, tbl_rd_q = '0;
    logic [4:0]  neighbor_count;
    logic [15:0] max_q, best_id, best_hops;
    logic        best_valid, upd_done, pkt_dropped;

    nbr_table_ctrl dut (
        .clock(clock), .reset(reset),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_id(pkt_id), .pkt_cluster(pkt_cluster), .pkt_energy(pkt_energy),
        .pkt_hops(pkt_hops), .pkt_q(pkt_q),
        .tbl_clr(tbl_clr), .tbl_addr(tbl_addr), .tbl_wr_en(tbl_wr_en),
        .tbl_wr_id(tbl_wr_id), .tbl_wr_cluster(tbl_wr_cluster),
        .tbl_wr_energy(tbl_wr_energy), .tbl_wr_hops(tbl_wr_hops), .tbl_wr_q(tbl_wr_q),
        .tbl_rd_id(tbl_rd_id), .tbl_rd_hops(tbl_rd_hops), .tbl_rd_q(tbl_rd_q),
        .neighbor_count(neighbor_count), .max_q(max_q), .best_id(best_id),
        .best_hops(best_hops), .best_valid(best_valid),
        .upd_done(upd_done), .pkt_dropped(pkt_dropped)
    );

    always #5 clock = ~clock;

    // Table memory: synchronous write, one-cycle registered read.
    logic [15:0] mem_id [16];
    logic [15:0] mem_hops [16];
    logic [15:0] mem_q [16];
    always @(posedge clock) begin
        if (tbl_wr_en) begin
            mem_id[tbl_addr]   <= tbl_wr_id;
            mem_hops[tbl_addr] <= tbl_wr_hops;
            mem_q[tbl_addr]    <= tbl_wr_q;
        end
        tbl_rd_id   <= mem_id[tbl_addr];
        tbl_rd_hops <= mem_hops[tbl_addr];
        tbl_rd_q    <= mem_q[tbl_addr];
    end

    int cyc = 0, wr_cnt = 0, drop_cnt = 0, done_cnt = 0;
    logic [3:0] last_wr_addr = '0;
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (tbl_wr_en) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= tbl_addr;
        end
        if (pkt_dropped) drop_cnt <= drop_cnt + 1;
        if (upd_done)    done_cnt <= done_cnt + 1;
    end

    int vectors = 0, miscompares = 0;
    int acc_cyc, lat, wr_before, done_before;
    logic drop_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic send(input logic [15:0] id, input logic [15:0] hp, input logic [15:0] q);
        logic got;
        pkt_id = id; pkt_cluster = id + 16'd1000; pkt_energy = 16'd500;
        pkt_hops = hp; pkt_q = q; pkt_valid = 1'b1;
        @(negedge clock);
        acc_cyc = cyc;
        chk("accept_ready", {31'd0, pkt_ready}, 1);
        @(posedge clock);
        #1 pkt_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (upd_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("upd_done_seen", {31'd0, got}, 1);
        lat = cyc - acc_cyc;
        drop_seen = pkt_dropped;
        @(negedge clock);
        chk("upd_done_width", {31'd0, upd_done}, 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic got;
        // Reset
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", {31'd0, pkt_ready}, 1);
        chk("rst_wr_en", {31'd0, tbl_wr_en}, 0);
        chk("rst_addr", {28'd0, tbl_addr}, 0);
        chk("rst_wr_id", {16'd0, tbl_wr_id}, 0);
        chk("rst_count", {27'd0, neighbor_count}, 0);
        chk("rst_max_q", {16'd0, max_q}, 0);
        chk("rst_best_id", {16'd0, best_id}, 32'hFFFF);
        chk("rst_best_hops", {16'd0, best_hops}, 32'hFFFF);
        chk("rst_best_valid", {31'd0, best_valid}, 0);
        chk("rst_upd_done", {31'd0, upd_done}, 0);
        chk("rst_dropped", {31'd0, pkt_dropped}, 0);
        @(posedge clock);
        #1;

        // First packet into empty table
        wr_before = wr_cnt;
        send(16'd5, 16'd2, 16'd100);
        chk("p1_latency", lat, 4);
        chk("p1_writes", wr_cnt - wr_before, 1);
        chk("p1_wr_addr", {28'd0, last_wr_addr}, 0);
        chk("p1_count", {27'd0, neighbor_count}, 1);
        chk("p1_best_id", {16'd0, best_id}, 5);
        chk("p1_max_q", {16'd0, max_q}, 100);
        chk("p1_best_hops", {16'd0, best_hops}, 2);
        chk("p1_best_valid", {31'd0, best_valid}, 1);
        chk("p1_wr_id_hold", {16'd0, tbl_wr_id}, 5);
        chk("p1_wr_q_hold", {16'd0, tbl_wr_q}, 100);

        // Append id 7
        wr_before = wr_cnt;
        send(16'd7, 16'd3, 16'd60);
        chk("p2_latency", lat, 8);
        chk("p2_wr_addr", {28'd0, last_wr_addr}, 1);
        chk("p2_count", {27'd0, neighbor_count}, 2);
        chk("p2_best_id", {16'd0, best_id}, 5);

        // Update id 5 (hit at 0) with lower Q
        wr_before = wr_cnt;
        send(16'd5, 16'd2, 16'd40);
        chk("p3_latency", lat, 8);
        chk("p3_writes", wr_cnt - wr_before, 1);
        chk("p3_wr_addr", {28'd0, last_wr_addr}, 0);
        chk("p3_count", {27'd0, neighbor_count}, 2);
        chk("p3_best_id", {16'd0, best_id}, 7);
        chk("p3_max_q", {16'd0, max_q}, 60);
        chk("p3_best_hops", {16'd0, best_hops}, 3);

        // Clear with a packet pending: clear wins, packet accepted next cycle
        wr_before = wr_cnt;
        pkt_id = 16'd3; pkt_hops = 16'd4; pkt_q = 16'd50;
        pkt_valid = 1'b1; tbl_clr = 1'b1;
        @(posedge clock);
        #1 tbl_clr = 1'b0;
        chk("clr_count", {27'd0, neighbor_count}, 0);
        chk("clr_best_valid", {31'd0, best_valid}, 0);
        chk("clr_ready", {31'd0, pkt_ready}, 1);
        send(16'd3, 16'd4, 16'd50);
        chk("clr_pkt_latency", lat, 4);
        chk("clr_pkt_writes", wr_cnt - wr_before, 1);
        chk("clr_pkt_addr", {28'd0, last_wr_addr}, 0);
        chk("clr_pkt_count", {27'd0, neighbor_count}, 1);

        // Equal-Q tie
        send(16'd9, 16'd1, 16'd50);
        chk("tie_wr_addr", {28'd0, last_wr_addr}, 1);
        chk("tie_max_q", {16'd0, max_q}, 50);
`ifdef HOP_TIEBREAK_EN
        chk("tie_best_id", {16'd0, best_id}, 9);
        chk("tie_best_hops", {16'd0, best_hops}, 1);
`else
        chk("tie_best_id", {16'd0, best_id}, 3);
        chk("tie_best_hops", {16'd0, best_hops}, 4);
`endif

        // Fill the table with 16 distinct IDs
        tbl_clr = 1'b1;
        @(posedge clock);
        #1 tbl_clr = 1'b0;
        for (int i = 0; i < 16; i++)
            send(16'(100 + i), 16'(i), 16'(10 * (i + 1)));
        chk("fill_count", {27'd0, neighbor_count}, 16);
        chk("fill_best_id", {16'd0, best_id}, 115);
        chk("fill_max_q", {16'd0, max_q}, 160);
        chk("fill_best_hops", {16'd0, best_hops}, 15);
        chk("fill_no_drops", drop_cnt, 0);

        // New ID into full table is dropped
        wr_before = wr_cnt;
        send(16'd99, 16'd0, 16'd999);
        chk("full_latency", lat, 34);
        chk("full_dropped_with_done", {31'd0, drop_seen}, 1);
        chk("full_no_write", wr_cnt - wr_before, 0);
        chk("full_drop_count", drop_cnt, 1);
        chk("full_count", {27'd0, neighbor_count}, 16);
        chk("full_best_id", {16'd0, best_id}, 115);
        chk("full_max_q", {16'd0, max_q}, 160);

        // Reset during the scan of a 3-entry update
        tbl_clr = 1'b1;
        @(posedge clock);
        #1 tbl_clr = 1'b0;
        send(16'd1, 16'd1, 16'd10);
        send(16'd2, 16'd1, 16'd20);
        chk("pre_rst_best_valid", {31'd0, best_valid}, 1);
        pkt_id = 16'd4; pkt_hops = 16'd1; pkt_q = 16'd30; pkt_valid = 1'b1;
        @(posedge clock);
        #1 pkt_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (tbl_wr_en) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst3_write_seen", {31'd0, got}, 1);
        done_before = done_cnt;
        @(posedge clock);   // C_ADDR
        @(posedge clock);   // C_CMP
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst3_ready", {31'd0, pkt_ready}, 1);
        chk("rst3_count", {27'd0, neighbor_count}, 0);
        chk("rst3_best_valid", {31'd0, best_valid}, 0);
        chk("rst3_wr_en", {31'd0, tbl_wr_en}, 0);
        repeat (8) @(negedge clock);
        chk("rst3_no_done", done_cnt - done_before, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
